axis_shrink_rr: RTL and testbench
=================================

AXIS_SHRINK_RR -- requirements
Module: axis_shrink_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 64: width of each input word; must be divisible by SHRINK.
REQ-002 SHALL have parameter SHRINK, default 4: narrow beats per input word; must be at least 2.
REQ-003 SHALL have parameter PORTS, default 2: number of wide input requesters; must be at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port s_rx_tdata, input, PORTS*WIDTH bits: port p occupies bits [p*WIDTH +: WIDTH].
REQ-007 SHALL have port s_rx_tvalid, input, PORTS bits: per-port word valid.
REQ-008 SHALL have port s_rx_tready, output, PORTS bits: per-port word accept; at most one bit high per cycle.
REQ-009 SHALL have port m_tx_tdata, output, WIDTH/SHRINK bits: narrow beat data.
REQ-010 SHALL have port m_tx_tvalid, output, 1 bit: narrow beat valid.
REQ-011 SHALL have port m_tx_tready, input, 1 bit: downstream ready.
REQ-012 SHALL have port m_tx_tlast, output, 1 bit: high on the last beat of each word.
REQ-013 SHALL have port m_tx_tid, output, $clog2(PORTS) bits: source port of the current word.
REQ-014 SHALL have port stat_words, output, 32 bits: count of completed words (see Configuration).

Function
REQ-015 SHALL have two states: IDLE (holding register empty) and XFER (holding register loaded, emitting beats).
REQ-016 SHALL, in IDLE with any s_rx_tvalid bit high, grant one port, assert only that port's s_rx_tready in the same cycle, load its word into the WIDTH-bit holding register, record it in m_tx_tid, set beat=0, and enter XFER.
REQ-017 SHALL arbitrate round-robin: search starts at (last_grant+1) mod PORTS; the winner becomes last_grant.
REQ-018 SHALL keep the grant locked for all SHRINK beats of a word; no re-arbitration happens mid-word.
REQ-019 SHALL, in XFER, drive m_tx_tvalid=1 and m_tx_tdata = holding[beat*WIDTH/SHRINK +: WIDTH/SHRINK], so the low slice goes first.
REQ-020 SHALL drive m_tx_tlast = (beat == SHRINK-1) while in XFER.
REQ-021 SHALL advance beat only on m_tx_tvalid && m_tx_tready; data, tid and tlast stay stable while stalled.
REQ-022 SHALL, on the last-beat handshake, accept a new word in the same cycle if any port is valid (XFER, beat=0); otherwise it enters IDLE. Back-to-back words therefore have no bubble.
REQ-023 SHALL hold s_rx_tready at 0 in every cycle other than the accept cycles of REQ-016 and REQ-022.
REQ-024 SHALL have a latency of 1 cycle from s_rx handshake to first m_tx_tvalid, and sustain 1 beat per cycle when m_tx_tready=1.
REQ-025 SHALL drive m_tx_tvalid=0 and m_tx_tlast=0 in IDLE.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set: state IDLE, beat 0, last_grant PORTS-1 (so port 0 wins first), m_tx_tid 0, holding 0, stat_words 0.
REQ-027 SHALL drive all s_rx_tready bits, m_tx_tvalid and m_tx_tlast to 0 during reset.
REQ-028 SHALL, on reset mid-word, discard the partially sent word; no remaining beats are emitted after release.

Configuration
REQ-029 SHALL, with AXIS_SHRINK_RR_STATS_EN defined, increment stat_words by 1 on each last-beat handshake, wrapping from 0xFFFFFFFF to 0.
REQ-030 SHALL, without AXIS_SHRINK_RR_STATS_EN, tie stat_words to 0 and omit the counter logic.

Verification (WIDTH=32, SHRINK=4, PORTS=2)
REQ-031 SHALL cover: port 0 sends 0xDDCCBBAA with m_tx_tready=1 -> s_rx_tready[0] high for 1 cycle; beats AA, BB, CC, DD on consecutive cycles; tid=0; tlast only on DD.
REQ-032 SHALL cover: both ports continuously valid with m_tx_tready=1 -> tid sequence 0,1,0,1; 16 beats in 16 consecutive cycles with no bubble.
REQ-033 SHALL cover: m_tx_tready=0 for 3 cycles after beat BB -> BB is held stable with tid unchanged; CC follows when tready returns.
REQ-034 SHALL cover: rst_n low for 1 cycle after 2 beats of a port 1 word -> m_tx_tvalid=0 the next cycle; after release with both ports valid, port 0 is granted first.
REQ-035 SHALL cover: 5 complete words sent -> stat_words=5 with AXIS_SHRINK_RR_STATS_EN defined, and 0 without it.

Source files
------------

// File: rtl/axis_shrink_rr.sv
// Round-robin arbiter that takes WIDTH-bit words from PORTS requesters and emits each as SHRINK narrow beats, low slice first.
// Optional word counter on stat_words is enabled by defining AXIS_SHRINK_RR_STATS_EN.
module axis_shrink_rr #(
    parameter int WIDTH  = 64,
    parameter int SHRINK = 4,
    parameter int PORTS  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS*WIDTH-1:0]     s_rx_tdata,
    input  logic [PORTS-1:0]           s_rx_tvalid,
    output logic [PORTS-1:0]           s_rx_tready,
    output logic [WIDTH/SHRINK-1:0]    m_tx_tdata,
    output logic                       m_tx_tvalid,
    input  logic                       m_tx_tready,
    output logic                       m_tx_tlast,
    output logic [$clog2(PORTS)-1:0]   m_tx_tid,
    output logic [31:0]                stat_words
);

    localparam int BW = WIDTH / SHRINK;
    localparam int TW = $clog2(PORTS);
    localparam int CW = $clog2(SHRINK);

    typedef enum logic {
        IDLE,
        XFER
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] holding_q, holding_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [TW-1:0]    last_grant_q, last_grant_d;
    logic [TW-1:0]    tid_q, tid_d;

    logic [TW-1:0]    grant;
    logic             found;
    logic             last_hs;
    logic             accept;

    // Search begins one past the previous winner so every requester gets a turn.
    always_comb begin
        int idx;
        grant = last_grant_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= PORTS; i++) begin
            idx = (int'(last_grant_q) + i) % PORTS;
            if (!found && s_rx_tvalid[idx]) begin
                grant = TW'(idx);
                found = 1'b1;
            end
        end
    end

    assign last_hs = (state_q == XFER) && m_tx_tready && (beat_q == CW'(SHRINK - 1));
    // A new word is taken when idle, or on the final beat handshake so words run back to back.
    assign accept  = rst_n && found && ((state_q == IDLE) || last_hs);

    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    always_comb begin
        state_d      = state_q;
        holding_d    = holding_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        tid_d        = tid_q;
        s_rx_tready  = '0;
        if (accept) begin
            s_rx_tready[grant] = 1'b1;
            holding_d          = s_rx_tdata[grant*WIDTH +: WIDTH];
            tid_d              = grant;
            last_grant_d       = grant;
            beat_d             = '0;
            state_d            = XFER;
        end else if (last_hs) begin
            beat_d  = '0;
            state_d = IDLE;
        end else if ((state_q == XFER) && m_tx_tready) begin
            beat_d = beat_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            last_grant_q <= TW'(PORTS - 1);
            tid_q        <= '0;
            // NOTE: the holding register is a plain flop bank, so clearing it on reset is cheap and keeps m_tx_tdata deterministic.
            holding_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            tid_q        <= tid_d;
            holding_q    <= holding_d;
        end
    end

    assign m_tx_tvalid = rst_n && (state_q == XFER);
    assign m_tx_tlast  = m_tx_tvalid && (beat_q == CW'(SHRINK - 1));
    assign m_tx_tdata  = holding_q[beat_q*BW +: BW];
    assign m_tx_tid    = tid_q;

`ifdef AXIS_SHRINK_RR_STATS_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (last_hs) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_words = stat_q;
`else
    assign stat_words = '0;
`endif

endmodule

// File: tb/tb_axis_shrink_rr.sv
// Scoreboard bench for axis_shrink_rr (WIDTH=32, SHRINK=4, PORTS=2) with a word-level reference model.
module tb_axis_shrink_rr;

    localparam int WIDTH  = 32;
    localparam int SHRINK = 4;
    localparam int PORTS  = 2;
    localparam int BW     = WIDTH / SHRINK;
`ifdef AXIS_SHRINK_RR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [PORTS*WIDTH-1:0] s_rx_tdata;
    logic [PORTS-1:0]       s_rx_tvalid;
    logic [PORTS-1:0]       s_rx_tready;
    logic [BW-1:0]          m_tx_tdata;
    logic                   m_tx_tvalid;
    logic                   m_tx_tready;
    logic                   m_tx_tlast;
    logic [0:0]             m_tx_tid;
    logic [31:0]            stat_words;

    axis_shrink_rr #(.WIDTH(WIDTH), .SHRINK(SHRINK), .PORTS(PORTS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_rx_tdata (s_rx_tdata),
        .s_rx_tvalid(s_rx_tvalid),
        .s_rx_tready(s_rx_tready),
        .m_tx_tdata (m_tx_tdata),
        .m_tx_tvalid(m_tx_tvalid),
        .m_tx_tready(m_tx_tready),
        .m_tx_tlast (m_tx_tlast),
        .m_tx_tid   (m_tx_tid),
        .stat_words (stat_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        int            tid;
        logic          last;
    } beat_t;

    int          n_vec  = 0;
    int          n_fail = 0;

    beat_t       exp_q[$];
    logic [31:0] src_q[PORTS][$];
    logic [PORTS-1:0] vld = '0;
    logic [PORTS-1:0] acc_q = '0;
    int          beats_left   = 0;
    int          last_grant_m = PORTS - 1;
    int          words_m      = 0;
    int          valid_pct    = 100;
    bit          tready_rand  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int rr_pick(input int last, input logic [PORTS-1:0] v);
        for (int i = 1; i <= PORTS; i++) begin
            if (v[(last + i) % PORTS]) return (last + i) % PORTS;
        end
        return -1;
    endfunction

    // Reference model and monitor: inputs are stable here, so this sees what the next edge will sample.
    always @(negedge clk) begin
        logic [PORTS-1:0] exp_ready;
        int g;
        beat_t b;
        if (!rst_n) begin
            check("rst_ready", 64'(s_rx_tready), 64'd0);
            check("rst_valid", 64'(m_tx_tvalid), 64'd0);
            check("rst_last", 64'(m_tx_tlast), 64'd0);
            exp_q.delete();
            beats_left   = 0;
            last_grant_m = PORTS - 1;
            words_m      = 0;
            acc_q        = '0;
        end else begin
            check("stat_words", 64'(stat_words), STATS ? 64'(words_m) : 64'd0);
            exp_ready = '0;
            g = -1;
            if (beats_left == 0 || (beats_left == 1 && m_tx_tready)) g = rr_pick(last_grant_m, s_rx_tvalid);
            if (g >= 0) exp_ready[g] = 1'b1;
            check("rx_ready", 64'(s_rx_tready), 64'(exp_ready));
            check("tx_valid", 64'(m_tx_tvalid), 64'(beats_left > 0));
            if (beats_left > 0) begin
                b = exp_q[0];
                check("tx_data", 64'(m_tx_tdata), 64'(b.data));
                check("tx_tid", 64'(m_tx_tid), 64'(b.tid));
                check("tx_last", 64'(m_tx_tlast), 64'(b.last));
                if (m_tx_tready) begin
                    void'(exp_q.pop_front());
                    beats_left--;
                    if (b.last) words_m++;
                end
            end else begin
                check("idle_last", 64'(m_tx_tlast), 64'd0);
            end
            if (g >= 0) begin
                for (int k = 0; k < SHRINK; k++) begin
                    b.data = s_rx_tdata[g*WIDTH + k*BW +: BW];
                    b.tid  = g;
                    b.last = (k == SHRINK - 1);
                    exp_q.push_back(b);
                end
                beats_left  += SHRINK;
                last_grant_m = g;
            end
            acc_q = s_rx_tready & s_rx_tvalid;
        end
    end

    // Source drivers: valid is held until accepted, then the next queued word may follow at once.
    initial begin
        s_rx_tdata  = '0;
        s_rx_tvalid = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < PORTS; p++) begin
                if (acc_q[p]) begin
                    void'(src_q[p].pop_front());
                    vld[p] = 1'b0;
                end
                if (src_q[p].size() == 0) vld[p] = 1'b0;
                else if (!vld[p] && $urandom_range(99) < valid_pct) vld[p] = 1'b1;
                s_rx_tdata[p*WIDTH +: WIDTH] = (src_q[p].size() > 0) ? src_q[p][0] : 32'h0;
            end
            s_rx_tvalid = vld;
            if (tready_rand) m_tx_tready = ($urandom_range(99) < 70);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() != 0 || src_q[1].size() != 0 || beats_left != 0) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) timeout_fail("drain");
        cyc();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_beat(input logic [BW-1:0] d, input logic [0:0] id, input string name);
        int n;
        n = 0;
        while (!(m_tx_tvalid && m_tx_tdata == d && m_tx_tid == id) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) timeout_fail(name);
    endtask

    initial begin
        rst_n       = 1'b0;
        m_tx_tready = 1'b1;
        repeat (3) cyc();
        check("reset_tid", 64'(m_tx_tid), 64'd0);
        check("reset_stat", 64'(stat_words), 64'd0);
        rst_n = 1'b1;

        // Single word from port 0 with an always-ready sink.
        src_q[0].push_back(32'hDDCCBBAA);
        wait_drain(100);

        // Both ports continuously valid: alternating grants, no bubbles.
        reset_pulse();
        src_q[0].push_back(32'h03020100);
        src_q[1].push_back(32'h13121110);
        src_q[0].push_back(32'h23222120);
        src_q[1].push_back(32'h33323130);
        wait_drain(200);

        // Sink stalls for three cycles while beat BB is presented.
        src_q[0].push_back(32'hDDCCBBAA);
        wait_beat(8'hBB, 1'b0, "wait_bb");
        m_tx_tready = 1'b0;
        repeat (3) cyc();
        m_tx_tready = 1'b1;
        wait_drain(100);

        // Randomised traffic and back-pressure.
        valid_pct   = 40;
        tready_rand = 1'b1;
        for (int w = 0; w < 60; w++) src_q[$urandom_range(PORTS - 1)].push_back($urandom);
        wait_drain(5000);
        tready_rand = 1'b0;
        m_tx_tready = 1'b1;
        valid_pct   = 100;

        // Reset after two beats of a port 1 word; port 0 must win afterwards.
        src_q[1].push_back(32'h44332211);
        wait_beat(8'h11, 1'b1, "wait_p1");
        cyc();
        cyc();
        reset_pulse();
        check("post_rst_valid", 64'(m_tx_tvalid), 64'd0);
        src_q[1].push_back(32'h77665544);
        src_q[0].push_back(32'h66554433);
        wait_drain(200);

        // Word counter after exactly five completed words.
        reset_pulse();
        for (int w = 0; w < 5; w++) src_q[w % PORTS].push_back($urandom);
        wait_drain(300);
        check("stat_words_5", 64'(stat_words), STATS ? 64'd5 : 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
